// File: rtl/gray_counter.sv
// Registered up/down counter that keeps a binary count and its Gray encoding in lock-step.
// Loads accept binary or Gray values. A one-cycle wrap pulse marks each modular wrap step.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap
);

  logic [WIDTH-1:0] load_dec;
  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  always_comb begin
    load_dec = '0;
    load_dec[WIDTH-1] = load_val[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      load_dec[i] = load_dec[i+1] ^ load_val[i];
    end
  end

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_is_gray ? load_dec : load_val;
    end else if (en) begin
      if (up) begin
        next_bin  = bin_q + 1'b1;
        next_wrap = (bin_q == '1);
      end else begin
        next_bin  = bin_q - 1'b1;
        next_wrap = (bin_q == '0);
      end
    end
  end

  // gray_q is registered from the encode of next_bin, so the output is glitch-free for CDC use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_bin ^ (next_bin >> 1);
      wrap   <= next_wrap;
    end
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised, registered up/down counter that keeps a binary count and its reflected-binary (Gray) encoding in lock-step.
- Successor to the 4-bit combinational binary-to-Gray converter. Adds:
  - a width parameter,
  - a clocked count with direction control,
  - a synchronous load that accepts either a binary or a Gray value,
  - a wrap indication.
- Intended as the pointer source for later clock-domain-crossing FIFO work. It sits beside the existing converter and does not replace it.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32; both outputs are WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per rising edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe; has priority over en.
- load_is_gray  input  1  1 = load_val is Gray coded, 0 = load_val is binary; sampled only when load=1.
- load_val  input  WIDTH  value to load.
- bin_q  output  WIDTH  registered binary count.
- gray_q  output  WIDTH  registered Gray count; always equals bin_q ^ (bin_q >> 1).
- wrap  output  1  registered one-cycle pulse marking a modular wrap on the step just taken.

Behaviour:
- Reset:
  - rst_n low drives bin_q=0, gray_q=0 and wrap=0 immediately, with no clock edge needed.
  - Outputs hold these values while rst_n is low.
  - The first active edge after rst_n rises behaves normally.
- Reset mid-operation: an in-progress count or load is abandoned; no partial update is visible.
- All updates happen on the rising edge of clk with 1-cycle latency: inputs sampled at edge N appear on outputs after edge N.
- Priority each edge: load, then en, then hold.
- Load (load=1):
  - If load_is_gray=0: next_bin = load_val.
  - If load_is_gray=1: next_bin is the Gray-to-binary decode of load_val: bit WIDTH-1 passes through; each lower bit i = XOR of load_val bits WIDTH-1 down to i.
  - gray_q gets the encode of next_bin.
  - wrap=0.
  - en and up are ignored that cycle.
- Count up (en=1, up=1):
  - next_bin = bin_q + 1 modulo 2^WIDTH.
  - wrap=1 only if bin_q was all-ones.
- Count down (en=1, up=0):
  - next_bin = bin_q - 1 modulo 2^WIDTH.
  - wrap=1 only if bin_q was zero.
- Hold (en=0, load=0): bin_q and gray_q unchanged; wrap=0.
- wrap is high for exactly one cycle per wrapping step. Consecutive wrapping steps each produce a pulse.
- No internal state machine beyond the bin_q register. gray_q is a register loaded from the encode of next_bin; it is not decoded combinationally from bin_q on the output path, so it is glitch-free for CDC use.
- Invariant: on every count step, including wrap in either direction, gray_q changes in exactly one bit. A load may change any number of bits.
- Direction reversal: up may change on any cycle; the step simply goes the new way. No extra state or penalty.
- Arithmetic is unsigned; overflow bits are discarded.
- No X propagation from load_val when load=0.

Test Plan:
- Reset check (WIDTH=4): assert rst_n=0 mid-count at bin_q=0110, between clock edges -> bin_q=0000, gray_q=0000, wrap=0 before the next edge; outputs stay 0 until rst_n=1.
- Count-up sweep (WIDTH=4): from 0000, en=1, up=1 for 16 edges -> gray_q follows 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - wrap=1 only on the 16th edge.
  - Exactly one gray_q bit toggles per edge.
- Count-down wrap (WIDTH=4): from 0000, en=1, up=0 for one edge -> bin_q=1111, gray_q=1000, wrap=1; next down edge -> bin_q=1110, gray_q=1001, wrap=0.
- Load both encodings (WIDTH=4):
  - load=1, load_is_gray=0, load_val=1010 -> bin_q=1010, gray_q=1111.
  - Then load=1, load_is_gray=1, load_val=1111 -> bin_q=1010, gray_q=1111.
  - load_is_gray=1, load_val=1000 -> bin_q=1111.
- Load priority (WIDTH=4): bin_q=0011; load=1, en=1, up=1, load_is_gray=0, load_val=1100 on the same edge -> bin_q=1100, gray_q=1010, wrap=0 (no increment).
- Wide instance (WIDTH=8): load binary 0xFF, then one up step -> bin_q=0x00, gray_q=0x00, wrap=1; hold for 3 edges -> outputs unchanged, wrap=0.
